// File: rtl/puf_soc_ctrl_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : puf_soc_ctrl_fsm                                           |
// | Description : Control FSM for one PUF challenge/response transaction     |
// |               (receive -> decode -> execute -> transmit). Latches the    |
// |               two mux selects from the received challenge, drives the    |
// |               datapath enables and state code, and reports done/error.   |
// | Config      : `define PUF_CTRL_TIMEOUT_EN to build the EXEC/TX timeout   |
// |               counter and the ERR state; otherwise o_err is tied to 0.   |
// | Ports       : clk, rst_n (async, active low)                             |
// |               i_start, i_abort, i_op_mode            host controls       |
// |               i_dp_rx_valid, i_dp_rx_data,                               |
// |               i_dp_exec_done, i_dp_tx_done           datapath status     |
// |               o_op_mode, o_rx_ready, o_dcod_en,                          |
// |               o_cnt_en, o_tx_en, o_fsm_state,                            |
// |               o_sel_mux_0, o_sel_mux_1               datapath controls   |
// |               o_busy, o_done, o_err                  host status         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module puf_soc_ctrl_fsm #(
  parameter int MUX_LENGTH  = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                i_start,
  input  logic                                i_abort,
  input  logic                                i_op_mode,
  input  logic                                i_dp_rx_valid,
  input  logic [2*$clog2(MUX_LENGTH)-1:0]     i_dp_rx_data,
  input  logic                                i_dp_exec_done,
  input  logic                                i_dp_tx_done,
  output logic                                o_op_mode,
  output logic                                o_rx_ready,
  output logic                                o_dcod_en,
  output logic                                o_cnt_en,
  output logic                                o_tx_en,
  output logic [2:0]                          o_fsm_state,
  output logic [$clog2(MUX_LENGTH)-1:0]       o_sel_mux_0,
  output logic [$clog2(MUX_LENGTH)-1:0]       o_sel_mux_1,
  output logic                                o_busy,
  output logic                                o_done,
  output logic                                o_err
);

  localparam int SEL_W = $clog2(MUX_LENGTH);

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_recv = 3'd1;
  localparam logic [2:0] c_st_dcod = 3'd2;
  localparam logic [2:0] c_st_exec = 3'd3;
  localparam logic [2:0] c_st_tx   = 3'd4;
  localparam logic [2:0] c_st_done = 3'd5;
  localparam logic [2:0] c_st_err  = 3'd6;

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic             w_tmo_hit;

  logic             w_op_mode;
  logic [SEL_W-1:0] w_sel_mux_0;
  logic [SEL_W-1:0] w_sel_mux_1;
  logic             w_err;

`ifdef PUF_CTRL_TIMEOUT_EN
  localparam int                 c_cnt_w    = $clog2(TIMEOUT_CYC);
  localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT_CYC - 1);

  logic [c_cnt_w-1:0] r_tmo_cnt;

  // Counts cycles spent in the current EXEC or TX visit. Any state change
  // (including EXEC -> TX) restarts it at 0, so the first cycle of a visit
  // always sees count 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if (((r_state == c_st_exec) || (r_state == c_st_tx)) && (w_next == r_state)) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  assign w_tmo_hit = (r_tmo_cnt == c_tmo_last);
`else
  assign w_tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. Abort outranks every other transition; the datapath
  // done inputs are checked before the timeout so a done on the final
  // counted cycle still completes normally.
  always_comb begin
    w_next = r_state;
    if (i_abort && (r_state != c_st_idle)) begin
      w_next = c_st_idle;
    end else begin
      case (r_state)
        c_st_idle: if (i_start)        w_next = c_st_recv;
        c_st_recv: if (i_dp_rx_valid)  w_next = c_st_dcod;
        c_st_dcod:                     w_next = c_st_exec;
        c_st_exec: begin
          if (i_dp_exec_done)          w_next = c_st_tx;
          else if (w_tmo_hit)          w_next = c_st_err;
        end
        c_st_tx: begin
          if (i_dp_tx_done)            w_next = c_st_done;
          else if (w_tmo_hit)          w_next = c_st_err;
        end
        c_st_done:                     w_next = c_st_idle;
        c_st_err:  if (i_start)        w_next = c_st_idle;
        default:                       w_next = c_st_idle;
      endcase
    end
  end

  // Output logic: Moore values decoded from the next state, plus the
  // hold-or-load values for the latched op mode and mux selects.
  always_comb begin
    w_op_mode   = o_op_mode;
    w_sel_mux_0 = o_sel_mux_0;
    w_sel_mux_1 = o_sel_mux_1;
    if ((r_state == c_st_idle) && i_start) begin
      w_op_mode = i_op_mode;
    end
    if ((r_state == c_st_recv) && i_dp_rx_valid && !i_abort) begin
      w_sel_mux_0 = i_dp_rx_data[SEL_W-1:0];
      w_sel_mux_1 = i_dp_rx_data[2*SEL_W-1:SEL_W];
    end
`ifdef PUF_CTRL_TIMEOUT_EN
    w_err = (w_next == c_st_err);
`else
    w_err = 1'b0;
`endif
  end

  // Output registers, all updated on the same edge as the state code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_op_mode   <= 1'b0;
      o_rx_ready  <= 1'b0;
      o_dcod_en   <= 1'b0;
      o_cnt_en    <= 1'b0;
      o_tx_en     <= 1'b0;
      o_sel_mux_0 <= '0;
      o_sel_mux_1 <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_op_mode   <= w_op_mode;
      o_rx_ready  <= (w_next == c_st_recv);
      o_dcod_en   <= (w_next == c_st_dcod);
      o_cnt_en    <= (w_next == c_st_exec);
      o_tx_en     <= (w_next == c_st_tx);
      o_sel_mux_0 <= w_sel_mux_0;
      o_sel_mux_1 <= w_sel_mux_1;
      o_busy      <= (w_next != c_st_idle) && (w_next != c_st_err);
      o_done      <= (w_next == c_st_done);
      o_err       <= w_err;
    end
  end

  assign o_fsm_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_puf_soc_ctrl_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_puf_soc_ctrl_fsm                                        |
// | Description : Directed self-checking bench for puf_soc_ctrl_fsm.         |
// |               Timeout scenarios are selected by PUF_CTRL_TIMEOUT_EN.     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_puf_soc_ctrl_fsm;

  localparam int MUX_LENGTH  = 16;
  localparam int TIMEOUT_CYC = 16;
`ifdef PUF_CTRL_TIMEOUT_EN
  localparam int EXEC_WAIT   = 10;
`else
  localparam int EXEC_WAIT   = 40;
`endif

  logic       clk;
  logic       rst_n;
  logic       i_start;
  logic       i_abort;
  logic       i_op_mode;
  logic       i_dp_rx_valid;
  logic [7:0] i_dp_rx_data;
  logic       i_dp_exec_done;
  logic       i_dp_tx_done;
  logic       o_op_mode;
  logic       o_rx_ready;
  logic       o_dcod_en;
  logic       o_cnt_en;
  logic       o_tx_en;
  logic [2:0] o_fsm_state;
  logic [3:0] o_sel_mux_0;
  logic [3:0] o_sel_mux_1;
  logic       o_busy;
  logic       o_done;
  logic       o_err;

  int n_checks;
  int n_pass;

  puf_soc_ctrl_fsm #(
    .MUX_LENGTH  (MUX_LENGTH),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_start        (i_start),
    .i_abort        (i_abort),
    .i_op_mode      (i_op_mode),
    .i_dp_rx_valid  (i_dp_rx_valid),
    .i_dp_rx_data   (i_dp_rx_data),
    .i_dp_exec_done (i_dp_exec_done),
    .i_dp_tx_done   (i_dp_tx_done),
    .o_op_mode      (o_op_mode),
    .o_rx_ready     (o_rx_ready),
    .o_dcod_en      (o_dcod_en),
    .o_cnt_en       (o_cnt_en),
    .o_tx_en        (o_tx_en),
    .o_fsm_state    (o_fsm_state),
    .o_sel_mux_0    (o_sel_mux_0),
    .o_sel_mux_1    (o_sel_mux_1),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_err          (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a transaction and walk it into the first EXEC cycle.
  task automatic go_exec(input logic mode, input logic [7:0] data);
    i_op_mode = mode;
    i_start   = 1'b1;
    tick();
    i_start   = 1'b0;
    i_dp_rx_valid = 1'b1;
    i_dp_rx_data  = data;
    tick();
    i_dp_rx_valid = 1'b0;
    i_dp_rx_data  = 8'h00;
    tick();
  endtask

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    rst_n          = 1'b0;
    i_start        = 1'b0;
    i_abort        = 1'b0;
    i_op_mode      = 1'b0;
    i_dp_rx_valid  = 1'b0;
    i_dp_rx_data   = 8'h00;
    i_dp_exec_done = 1'b0;
    i_dp_tx_done   = 1'b0;

    // Reset
    for (int i = 0; i < 5; i++) tick();
    check("rst_state",   o_fsm_state, 3'd0);
    check("rst_rxrdy",   o_rx_ready,  1'b0);
    check("rst_dcod",    o_dcod_en,   1'b0);
    check("rst_cnt",     o_cnt_en,    1'b0);
    check("rst_tx",      o_tx_en,     1'b0);
    check("rst_sel0",    o_sel_mux_0, 4'h0);
    check("rst_sel1",    o_sel_mux_1, 4'h0);
    check("rst_busy",    o_busy,      1'b0);
    check("rst_done",    o_done,      1'b0);
    check("rst_err",     o_err,       1'b0);
    check("rst_opmode",  o_op_mode,   1'b0);
    rst_n = 1'b1;
    tick();
    check("idle_hold", o_fsm_state, 3'd0);

    // Nominal transaction with op mode 1
    i_start   = 1'b1;
    i_op_mode = 1'b1;
    tick();
    check("nom_recv_state", o_fsm_state, 3'd1);
    check("nom_rxrdy",      o_rx_ready,  1'b1);
    check("nom_busy",       o_busy,      1'b1);
    check("nom_opmode",     o_op_mode,   1'b1);
    i_start   = 1'b0;
    i_op_mode = 1'b0;
    tick();
    check("nom_recv_wait", o_fsm_state, 3'd1);
    i_dp_rx_valid = 1'b1;
    i_dp_rx_data  = 8'hA5;
    tick();
    check("nom_dcod_state", o_fsm_state, 3'd2);
    check("nom_dcod_en",    o_dcod_en,   1'b1);
    check("nom_rxrdy_off",  o_rx_ready,  1'b0);
    check("nom_sel0",       o_sel_mux_0, 4'h5);
    check("nom_sel1",       o_sel_mux_1, 4'hA);
    i_dp_rx_valid = 1'b0;
    i_dp_rx_data  = 8'h3C;
    tick();
    check("nom_exec_state", o_fsm_state, 3'd3);
    check("nom_dcod_off",   o_dcod_en,   1'b0);
    check("nom_cnt_en",     o_cnt_en,    1'b1);
    check("nom_sel0_hold",  o_sel_mux_0, 4'h5);
    // start while busy must be ignored
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("nom_start_ign", o_fsm_state, 3'd3);
    for (int i = 2; i < EXEC_WAIT; i++) tick();
    check("nom_exec_wait", o_fsm_state, 3'd3);
    check("nom_cnt_held",  o_cnt_en,    1'b1);
    check("nom_opmode_held", o_op_mode, 1'b1);
    i_dp_exec_done = 1'b1;
    tick();
    i_dp_exec_done = 1'b0;
    check("nom_tx_state", o_fsm_state, 3'd4);
    check("nom_tx_en",    o_tx_en,     1'b1);
    check("nom_cnt_off",  o_cnt_en,    1'b0);
    tick();
    check("nom_tx_wait",  o_tx_en,     1'b1);
    i_dp_tx_done = 1'b1;
    tick();
    i_dp_tx_done = 1'b0;
    check("nom_done_state", o_fsm_state, 3'd5);
    check("nom_done",       o_done,      1'b1);
    check("nom_tx_off",     o_tx_en,     1'b0);
    check("nom_done_busy",  o_busy,      1'b1);
    tick();
    check("nom_end_state", o_fsm_state, 3'd0);
    check("nom_done_off",  o_done,      1'b0);
    check("nom_end_busy",  o_busy,      1'b0);
    check("nom_end_sel1",  o_sel_mux_1, 4'hA);
    check("nom_end_opm",   o_op_mode,   1'b1);

    // New start reloads op mode; abort in EXEC
    go_exec(1'b0, 8'h3C);
    check("ab1_opmode", o_op_mode,   1'b0);
    check("ab1_sel0",   o_sel_mux_0, 4'hC);
    check("ab1_sel1",   o_sel_mux_1, 4'h3);
    check("ab1_exec",   o_fsm_state, 3'd3);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("ab1_state", o_fsm_state, 3'd0);
    check("ab1_cnt",   o_cnt_en,    1'b0);
    check("ab1_done",  o_done,      1'b0);
    check("ab1_busy",  o_busy,      1'b0);

    // Abort in TX
    go_exec(1'b1, 8'h96);
    i_dp_exec_done = 1'b1;
    tick();
    i_dp_exec_done = 1'b0;
    check("ab2_tx", o_fsm_state, 3'd4);
    i_abort      = 1'b1;
    i_dp_tx_done = 1'b1;
    tick();
    i_abort      = 1'b0;
    i_dp_tx_done = 1'b0;
    check("ab2_state", o_fsm_state, 3'd0);
    check("ab2_txen",  o_tx_en,     1'b0);
    check("ab2_done",  o_done,      1'b0);
    tick();
    check("ab2_done2", o_done,      1'b0);

    // Abort ignored in IDLE, honoured in RECV; rx_valid with abort does not latch
    i_abort = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("ab3_idle_ign", o_fsm_state, 3'd1);
    i_dp_rx_valid = 1'b1;
    i_dp_rx_data  = 8'hFF;
    tick();
    i_abort       = 1'b0;
    i_dp_rx_valid = 1'b0;
    check("ab3_recv",  o_fsm_state, 3'd0);
    check("ab3_sel0",  o_sel_mux_0, 4'h6);
    check("ab3_rxrdy", o_rx_ready,  1'b0);

    // Asynchronous reset mid-transaction
    go_exec(1'b1, 8'h12);
    rst_n = 1'b0;
    #1;
    check("arst_state", o_fsm_state, 3'd0);
    check("arst_cnt",   o_cnt_en,    1'b0);
    check("arst_sel0",  o_sel_mux_0, 4'h0);
    check("arst_opm",   o_op_mode,   1'b0);
    tick();
    rst_n = 1'b1;
    tick();

`ifdef PUF_CTRL_TIMEOUT_EN
    // No exec_done: 16 EXEC cycles then ERR
    go_exec(1'b0, 8'h21);
    for (int i = 1; i < TIMEOUT_CYC; i++) tick();
    check("to_exec15", o_fsm_state, 3'd3);
    check("to_err15",  o_err,       1'b0);
    tick();
    check("to_state",  o_fsm_state, 3'd6);
    check("to_err",    o_err,       1'b1);
    check("to_cnt",    o_cnt_en,    1'b0);
    check("to_busy",   o_busy,      1'b0);
    tick();
    check("to_sticky", o_err,       1'b1);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("to_clr_state", o_fsm_state, 3'd0);
    check("to_clr_err",   o_err,       1'b0);
    tick();
    check("to_no_reuse",  o_fsm_state, 3'd0);

    // exec_done on the 16th EXEC cycle wins over the timeout
    go_exec(1'b0, 8'h43);
    for (int i = 1; i < TIMEOUT_CYC; i++) tick();
    i_dp_exec_done = 1'b1;
    tick();
    i_dp_exec_done = 1'b0;
    check("edge_tx",  o_fsm_state, 3'd4);
    check("edge_err", o_err,       1'b0);
    // TX timeout counter restarts at TX entry
    for (int i = 1; i < TIMEOUT_CYC; i++) tick();
    check("tx_to15", o_fsm_state, 3'd4);
    tick();
    check("tx_to_state", o_fsm_state, 3'd6);
    check("tx_to_err",   o_err,       1'b1);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("err_abort",   o_fsm_state, 3'd0);
    check("err_abort_e", o_err,       1'b0);
`else
    // Without the timeout, EXEC waits indefinitely
    go_exec(1'b0, 8'h43);
    for (int i = 0; i < 5000; i++) tick();
    check("noto_exec", o_fsm_state, 3'd3);
    check("noto_err",  o_err,       1'b0);
    i_dp_exec_done = 1'b1;
    tick();
    i_dp_exec_done = 1'b0;
    check("noto_tx", o_fsm_state, 3'd4);
    i_dp_tx_done = 1'b1;
    tick();
    i_dp_tx_done = 1'b0;
    check("noto_done", o_done, 1'b1);
    tick();
    check("noto_idle", o_fsm_state, 3'd0);
    check("noto_err2", o_err,       1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
